fg_vram_cpu_port: RTL
=====================

Name: fg_vram_cpu_port

Overview:
- CPU-side initiator for the foreground tile-map RAMs (character and attribute), running on master_clk.
- Decodes Z80 memory cycles to the two RAM windows and waits for the foreground layer's tile-phase access slot.
- Issues exactly one write strobe or one read capture per CPU cycle and drives the Z80 WAIT line until the access completes.
- Sits between the CPU bus and the foreground layer's CPU port: chip selects, write enable, address and data out; read data back.

Parameters:
- CHR_BASE, 16'hF000, base of 2 KB character RAM window (CPU_ADDR[15:11] match)
- ATR_BASE, 16'hF800, base of 2 KB attribute RAM window
- ACC_CYCLES, 3, master_clk cycles held in ACCESS state (≥2)
- SLOT_TIMEOUT, 64, max cycles spent in SYNC waiting for a slot before forcing the access

Ports:
- master_clk  in  1  sole clock
- reset_n  in  1  synchronous, active-low reset
- cpu_mreq_n  in  1  Z80 MREQ
- cpu_rd_n  in  1  Z80 RD
- cpu_wr_n  in  1  Z80 WR
- cpu_addr  in  16  Z80 address
- cpu_dout  in  8  Z80 write data
- fg_clk  in  1  tile-phase level from the foreground layer; a falling edge marks an access slot
- cpu_din  out  8  read data to CPU
- cpu_wait_n  out  1  Z80 WAIT, low = stall
- vram_chr_cs_n  out  1  character RAM select
- vram_atr_cs_n  out  1  attribute RAM select
- vram_wr_n  out  1  write strobe
- vram_addr  out  11  RAM address, cpu_addr[10:0] latched
- vram_din  out  8  RAM write data, latched
- fg_lo_q  in  8  character RAM read data, registered (1-cycle latency)
- fg_hi_q  in  8  attribute RAM read data, registered (1-cycle latency)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n low at a master_clk edge):
  - state=IDLE; cpu_wait_n=1; both cs_n=1; vram_wr_n=1.
  - cpu_din=8'h00; vram_addr=0; vram_din=0; busy=0; fg_clk_d=0; counters=0.
- Request:
  - req = !cpu_mreq_n & (!cpu_rd_n | !cpu_wr_n) & (cpu_addr[15:11]==CHR_BASE[15:11] or ATR_BASE[15:11]).
  - If both rd and wr are low, it is treated as a write.
- Slot: slot = fg_clk_d & !fg_clk, where fg_clk_d is fg_clk registered every cycle.
- IDLE:
  - On req, latch addr[10:0], dout, the rd/wr kind and the window (chr/atr).
  - cpu_wait_n goes low in the same registered update. Next state SYNC.
- SYNC:
  - Assert the latched window's cs_n low. Count cycles.
  - On slot, or when the count reaches SLOT_TIMEOUT-1, go to ACCESS and clear the count.
- ACCESS:
  - Lasts ACC_CYCLES cycles.
  - Write: vram_wr_n low only in the first ACCESS cycle; vram_din stable throughout.
  - Read: capture fg_lo_q or fg_hi_q (by window) into cpu_din in the last ACCESS cycle. The RAM has 1-cycle latency, hence ACC_CYCLES≥2.
  - Then go to DONE.
- DONE:
  - cs_n=1; cpu_wait_n=1; cpu_din holds.
  - Return to IDLE only when cpu_mreq_n=1. This guarantees one access per CPU cycle.
- Abort:
  - If cpu_mreq_n rises in SYNC, return to IDLE, deassert wait and cs_n, and issue no write.
  - In ACCESS the access completes regardless, then the FSM proceeds to DONE.
  - If mreq is already high in DONE, exit to IDLE next cycle.
- Non-window addresses never leave IDLE; cpu_wait_n stays 1.
- Back-to-back: a new req seen in the cycle after DONE→IDLE is accepted normally.
- Latency:
  - Minimum, with the slot on the first SYNC cycle: wait low for 1 (SYNC) + ACC_CYCLES cycles.
  - Maximum: SLOT_TIMEOUT + ACC_CYCLES.
- Reset mid-operation aborts any state to IDLE with the reset values above. A write in flight is dropped if vram_wr_n has not yet been sampled low.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles mid-SYNC -> next cycle cpu_wait_n=1, cs_n=11, vram_wr_n=1, cpu_din=00, busy=0.
- Char write: addr F123, dout 5A, WR low; fg_clk falls 4 cycles later -> vram_chr_cs_n low, then one vram_wr_n pulse with vram_addr=123 and vram_din=5A; wait released after ACC_CYCLES=3; exactly 1 strobe.
- Attr read: addr F8FF, RD low, fg_hi_q=C3 -> cpu_din=C3 when wait releases; vram_atr_cs_n used; vram_wr_n never low.
- Timeout: fg_clk held constant, read F000 -> ACCESS entered after 64 SYNC cycles; wait low for 64+3 cycles total.
- Abort: write F010 and deassert mreq in SYNC before any slot -> no vram_wr_n pulse; state IDLE; wait=1 next cycle.
- Decode/hold: read at E000 -> no busy, wait stays 1. A valid read with mreq held low for 20 cycles after DONE -> single access; IDLE entered 1 cycle after mreq rises.

Source files
------------

// File: rtl/fg_vram_cpu_port_if.sv
// Bus bundle between the Z80 side, the CPU-port initiator and the foreground
// layer's tile-map RAM port. The slave modport is the initiator's view.
interface fg_vram_cpu_port_if;
    logic        cpu_mreq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_wait_n;
    logic        fg_clk;
    logic        vram_chr_cs_n;
    logic        vram_atr_cs_n;
    logic        vram_wr_n;
    logic [10:0] vram_addr;
    logic [7:0]  vram_din;
    logic [7:0]  fg_lo_q;
    logic [7:0]  fg_hi_q;
    logic        busy;

    // CPU / foreground-layer side: drives requests and RAM read data
    modport master (
        output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
        output fg_clk, fg_lo_q, fg_hi_q,
        input  cpu_din, cpu_wait_n, vram_chr_cs_n, vram_atr_cs_n,
        input  vram_wr_n, vram_addr, vram_din, busy
    );

    // Initiator side
    modport slave (
        input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_addr, cpu_dout,
        input  fg_clk, fg_lo_q, fg_hi_q,
        output cpu_din, cpu_wait_n, vram_chr_cs_n, vram_atr_cs_n,
        output vram_wr_n, vram_addr, vram_din, busy
    );
endinterface

// File: rtl/fg_vram_cpu_port.sv
// CPU-side initiator for the foreground character/attribute tile-map RAMs.
// A Z80 memory cycle hitting either 2 KB window is latched, the CPU is
// stalled via WAIT, and exactly one RAM write strobe or read capture is
// performed in the next foreground tile-phase slot (falling edge of fg_clk),
// or after SLOT_TIMEOUT cycles if no slot arrives.
module fg_vram_cpu_port #(
    parameter logic [15:0] CHR_BASE     = 16'hF000,
    parameter logic [15:0] ATR_BASE     = 16'hF800,
    parameter int          ACC_CYCLES   = 3,
    parameter int          SLOT_TIMEOUT = 64
) (
    input  logic                 master_clk,
    input  logic                 reset_n,
    fg_vram_cpu_port_if.slave    bus
);

    localparam int CNT_MAX = (SLOT_TIMEOUT > ACC_CYCLES) ? SLOT_TIMEOUT : ACC_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               fg_clk_d;
    logic               kind_wr;
    logic               win_atr;

    logic               hit_chr;
    logic               hit_atr;
    logic               req;
    logic               slot;

    // Window decode and tile-phase slot detection (feed registers only)
    assign hit_chr = (bus.cpu_addr[15:11] == CHR_BASE[15:11]);
    assign hit_atr = (bus.cpu_addr[15:11] == ATR_BASE[15:11]);
    assign req     = !bus.cpu_mreq_n && (!bus.cpu_rd_n || !bus.cpu_wr_n) && (hit_chr || hit_atr);
    assign slot    = fg_clk_d && !bus.fg_clk;

    // Access sequencer: all bus and RAM outputs are registered here
    always_ff @(posedge master_clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            fg_clk_d          <= 1'b0;
            kind_wr           <= 1'b0;
            win_atr           <= 1'b0;
            bus.cpu_wait_n    <= 1'b1;
            bus.vram_chr_cs_n <= 1'b1;
            bus.vram_atr_cs_n <= 1'b1;
            bus.vram_wr_n     <= 1'b1;
            bus.cpu_din       <= 8'h00;
            bus.vram_addr     <= '0;
            bus.vram_din      <= '0;
            bus.busy          <= 1'b0;
        end else begin
            fg_clk_d <= bus.fg_clk;
            case (state)
                IDLE: begin
                    if (req) begin
                        // Both strobes low counts as a write
                        kind_wr           <= !bus.cpu_wr_n;
                        win_atr           <= !hit_chr;
                        bus.vram_addr     <= bus.cpu_addr[10:0];
                        bus.vram_din      <= bus.cpu_dout;
                        bus.cpu_wait_n    <= 1'b0;
                        bus.vram_chr_cs_n <= !hit_chr;
                        bus.vram_atr_cs_n <= hit_chr;
                        bus.busy          <= 1'b1;
                        cnt               <= '0;
                        state             <= SYNC;
                    end
                end
                SYNC: begin
                    if (bus.cpu_mreq_n) begin
                        // CPU abandoned the cycle before any RAM activity
                        bus.cpu_wait_n    <= 1'b1;
                        bus.vram_chr_cs_n <= 1'b1;
                        bus.vram_atr_cs_n <= 1'b1;
                        bus.busy          <= 1'b0;
                        cnt               <= '0;
                        state             <= IDLE;
                    end else if (slot || (cnt == CNT_W'(SLOT_TIMEOUT - 1))) begin
                        bus.vram_wr_n <= !kind_wr;
                        cnt           <= '0;
                        state         <= ACCESS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    // Strobe is a single-cycle pulse at the start of ACCESS
                    bus.vram_wr_n <= 1'b1;
                    if (cnt == CNT_W'(ACC_CYCLES - 1)) begin
                        // RAM read data has settled by now (1-cycle latency)
                        if (!kind_wr) begin
                            bus.cpu_din <= win_atr ? bus.fg_hi_q : bus.fg_lo_q;
                        end
                        bus.cpu_wait_n    <= 1'b1;
                        bus.vram_chr_cs_n <= 1'b1;
                        bus.vram_atr_cs_n <= 1'b1;
                        cnt               <= '0;
                        state             <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Hold until MREQ rises so one CPU cycle yields one access
                    if (bus.cpu_mreq_n) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
